idma_axis_traffic_gen_chk: RTL and testbench

Multi-channel AXI-Stream traffic generator and checker used as a synthesizable stimulus/response block around the iDMA streaming backends. Per channel it drives a deterministic incrementing-data packet toward a streaming read port and checks the packet returned on a streaming write port, keyed by TID. Packets are arbitrated round-robin, and per-channel error counters and status are exposed.

---
 rtl/idma_axis_traffic_gen_chk_if.sv | 17 +
 rtl/idma_axis_traffic_gen_chk.sv | 214 +++++++++++++++++++++
 tb/tb_idma_axis_traffic_gen_chk.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idma_axis_traffic_gen_chk_if.sv
// AXI-Stream bundle shared by the generator (master) and checker (slave) ports.
interface idma_axis_traffic_gen_chk_if #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned StrbWidth = DataWidth / 8,
  parameter int unsigned IdWidth   = 3
);
  logic                 tvalid;
  logic                 tready;
  logic [DataWidth-1:0] tdata;
  logic [StrbWidth-1:0] tstrb;
  logic [StrbWidth-1:0] tkeep;
  logic [IdWidth-1:0]   tid;
  logic                 tlast;

  modport master (output tvalid, tdata, tstrb, tkeep, tid, tlast, input tready);
  modport slave  (input tvalid, tdata, tid, tlast, output tready);
endinterface

// File: rtl/idma_axis_traffic_gen_chk.sv
// Multi-channel AXI-Stream incrementing-data packet generator with a TID-keyed
// return-path checker, round-robin packet arbitration and saturating error counters.
module idma_axis_traffic_gen_chk #(
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned StrbWidth   = DataWidth / 8,
  parameter int unsigned NumChannels = 2,
  parameter int unsigned IdWidth     = 3,
  parameter int unsigned LenWidth    = 24,
  parameter int unsigned ErrCntWidth = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumChannels-1:0]            start_i,
  input  logic [NumChannels*LenWidth-1:0]   len_i,
  input  logic [NumChannels*DataWidth-1:0]  seed_i,
  idma_axis_traffic_gen_chk_if.master       gen,
  idma_axis_traffic_gen_chk_if.slave        chk,
  output logic [NumChannels-1:0]            busy_o,
  output logic [NumChannels-1:0]            done_o,
  output logic [NumChannels*ErrCntWidth-1:0] err_cnt_o,
  output logic [ErrCntWidth-1:0]            stray_cnt_o
);

  localparam int unsigned CntW = ErrCntWidth + 1;

  // Per-channel configuration and state
  logic [NumChannels-1:0] gen_act_q, gen_act_d;
  logic [NumChannels-1:0] chk_arm_q, chk_arm_d;
  logic [NumChannels-1:0] done_q, done_d;
  logic [NumChannels-1:0] busy_q, busy_d;
  logic [LenWidth-1:0]    len_q [NumChannels];
  logic [LenWidth-1:0]    len_d [NumChannels];
  logic [DataWidth-1:0]   seed_q [NumChannels];
  logic [DataWidth-1:0]   seed_d [NumChannels];
  logic [LenWidth-1:0]    chk_beat_q [NumChannels];
  logic [LenWidth-1:0]    chk_beat_d [NumChannels];
  logic [ErrCntWidth-1:0] err_q [NumChannels];
  logic [ErrCntWidth-1:0] err_d [NumChannels];
  logic [ErrCntWidth-1:0] stray_q, stray_d;

  // Generator bus state; tvalid_q doubles as "an owner exists"
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic [DataWidth-1:0] tdata_q, tdata_d;
  logic [IdWidth-1:0]   tid_q, tid_d;
  logic [IdWidth-1:0]   rr_q, rr_d;
  logic [LenWidth-1:0]  beat_q, beat_d;
  logic [LenWidth-1:0]  own_len_q, own_len_d;
  logic                 en_q;

  logic                 found;
  logic                 hit;
  logic [DataWidth-1:0] exp_data;
  logic                 exp_last;
  logic [1:0]           err_inc;
  logic [CntW-1:0]      err_sum;

  always_comb begin
    gen_act_d  = gen_act_q;
    chk_arm_d  = chk_arm_q;
    done_d     = done_q;
    len_d      = len_q;
    seed_d     = seed_q;
    chk_beat_d = chk_beat_q;
    err_d      = err_q;
    stray_d    = stray_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tdata_d    = tdata_q;
    tid_d      = tid_q;
    rr_d       = rr_q;
    beat_d     = beat_q;
    own_len_d  = own_len_q;
    found      = 1'b0;
    hit        = 1'b0;
    exp_data   = '0;
    exp_last   = 1'b0;
    err_inc    = '0;
    err_sum    = '0;

    // Start is honoured only when both halves of the channel are idle
    for (int c = 0; c < int'(NumChannels); c++) begin
      if (start_i[c] && !gen_act_q[c] && !chk_arm_q[c]) begin
        len_d[c]      = len_i[c*LenWidth +: LenWidth];
        seed_d[c]     = seed_i[c*DataWidth +: DataWidth];
        done_d[c]     = 1'b0;
        err_d[c]      = '0;
        chk_beat_d[c] = '0;
        gen_act_d[c]  = 1'b1;
        chk_arm_d[c]  = 1'b1;
      end
    end

    // Generator: hold the owner until its tlast handshake, then leave one bubble
    if (tvalid_q) begin
      if (gen.tready) begin
        if (tlast_q) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          for (int c = 0; c < int'(NumChannels); c++) begin
            if (tid_q == IdWidth'(c)) begin
              gen_act_d[c] = 1'b0;
              rr_d = (c == int'(NumChannels) - 1) ? '0 : IdWidth'(c + 1);
            end
          end
        end else begin
          beat_d  = beat_q + LenWidth'(1);
          tdata_d = tdata_q + DataWidth'(1);
          tlast_d = (beat_d == own_len_q);
        end
      end
    end else begin
      for (int i = 0; i < int'(NumChannels); i++) begin
        for (int c = 0; c < int'(NumChannels); c++) begin
          if (!found && gen_act_q[c] && (c == (int'(rr_q) + i) % int'(NumChannels))) begin
            found     = 1'b1;
            tvalid_d  = 1'b1;
            tid_d     = IdWidth'(c);
            tdata_d   = seed_q[c];
            beat_d    = '0;
            own_len_d = len_q[c];
            tlast_d   = (len_q[c] == '0);
          end
        end
      end
    end

    // Checker: compare against the expected beat; unmatched beats are strays
    if (chk.tvalid && en_q) begin
      for (int c = 0; c < int'(NumChannels); c++) begin
        if (chk.tid == IdWidth'(c) && chk_arm_q[c]) begin
          hit      = 1'b1;
          exp_data = seed_q[c] + DataWidth'(chk_beat_q[c]);
          exp_last = (chk_beat_q[c] == len_q[c]);
          err_inc  = 2'(chk.tdata != exp_data) + 2'(chk.tlast != exp_last);
          err_sum  = {1'b0, err_q[c]} + CntW'(err_inc);
          err_d[c] = err_sum[ErrCntWidth] ? '1 : err_sum[ErrCntWidth-1:0];
          if (exp_last || chk.tlast) begin
            chk_arm_d[c] = 1'b0;
            done_d[c]    = 1'b1;
          end else begin
            chk_beat_d[c] = chk_beat_q[c] + LenWidth'(1);
          end
        end
      end
      if (!hit) begin
        stray_d = (&stray_q) ? stray_q : stray_q + ErrCntWidth'(1);
      end
    end

    busy_d = gen_act_d | chk_arm_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q      <= 1'b0;
      gen_act_q <= '0;
      chk_arm_q <= '0;
      done_q    <= '0;
      busy_q    <= '0;
      stray_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      tid_q     <= '0;
      rr_q      <= '0;
      beat_q    <= '0;
      own_len_q <= '0;
      for (int c = 0; c < int'(NumChannels); c++) begin
        len_q[c]      <= '0;
        seed_q[c]     <= '0;
        chk_beat_q[c] <= '0;
        err_q[c]      <= '0;
      end
    end else begin
      en_q       <= 1'b1;
      gen_act_q  <= gen_act_d;
      chk_arm_q  <= chk_arm_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      stray_q    <= stray_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
      tid_q      <= tid_d;
      rr_q       <= rr_d;
      beat_q     <= beat_d;
      own_len_q  <= own_len_d;
      len_q      <= len_d;
      seed_q     <= seed_d;
      chk_beat_q <= chk_beat_d;
      err_q      <= err_d;
    end
  end

  assign gen.tvalid  = tvalid_q;
  assign gen.tdata   = tdata_q;
  assign gen.tid     = tid_q;
  assign gen.tlast   = tlast_q;
  assign gen.tstrb   = {StrbWidth{en_q}};
  assign gen.tkeep   = {StrbWidth{en_q}};
  assign chk.tready  = en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign stray_cnt_o = stray_q;

  always_comb begin
    err_cnt_o = '0;
    for (int c = 0; c < int'(NumChannels); c++) begin
      err_cnt_o[c*ErrCntWidth +: ErrCntWidth] = err_q[c];
    end
  end

endmodule

// File: tb/tb_idma_axis_traffic_gen_chk.sv
// Bench for idma_axis_traffic_gen_chk: vector table, directed corner sequences and
// random backpressure against a packet-level scoreboard.
module tb_idma_axis_traffic_gen_chk;
  localparam int unsigned NCH = 2;
  localparam int unsigned DW  = 64;
  localparam int unsigned IDW = 3;
  localparam int unsigned LW  = 24;
  localparam int unsigned EW  = 16;

  logic               clk, rst;
  logic [NCH-1:0]     start;
  logic [NCH*LW-1:0]  len_flat;
  logic [NCH*DW-1:0]  seed_flat;
  logic [NCH-1:0]     busy, done;
  logic [NCH*EW-1:0]  err_cnt;
  logic [EW-1:0]      stray_cnt;

  logic          lb, rdy_fix, rdy_rand, rnd_rdy, drop_last;
  int            corrupt_at, force_at, lb_beat;
  logic          man_valid, man_last;
  logic [DW-1:0] man_data;
  logic [IDW-1:0] man_tid;

  idma_axis_traffic_gen_chk_if #(.DataWidth(DW), .IdWidth(IDW)) gen_if ();
  idma_axis_traffic_gen_chk_if #(.DataWidth(DW), .IdWidth(IDW)) chk_if ();

  assign gen_if.tready = rdy_rand ? rnd_rdy : rdy_fix;
  assign chk_if.tvalid = lb ? (gen_if.tvalid & gen_if.tready) : man_valid;
  assign chk_if.tdata  = lb ? (gen_if.tdata ^ {{(DW-1){1'b0}}, (lb_beat == corrupt_at)}) : man_data;
  assign chk_if.tid    = lb ? gen_if.tid : man_tid;
  assign chk_if.tlast  = lb ? ((gen_if.tlast & ~drop_last) | (lb_beat == force_at)) : man_last;
  assign chk_if.tstrb  = gen_if.tstrb;
  assign chk_if.tkeep  = gen_if.tkeep;

  idma_axis_traffic_gen_chk #(
    .DataWidth(DW), .NumChannels(NCH), .IdWidth(IDW), .LenWidth(LW), .ErrCntWidth(EW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len_flat), .seed_i(seed_flat),
    .gen(gen_if), .chk(chk_if), .busy_o(busy), .done_o(done),
    .err_cnt_o(err_cnt), .stray_cnt_o(stray_cnt)
  );

  always #5 clk = ~clk;

  // Beat index within the current looped-back packet
  always @(posedge clk or posedge rst) begin
    if (rst) lb_beat <= 0;
    else if (gen_if.tvalid && gen_if.tready) lb_beat <= gen_if.tlast ? 0 : lb_beat + 1;
  end

  int n_vec, n_err;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Scoreboard: per-channel packet parameters and next expected beat
  logic [DW-1:0] mdl_seed [NCH];
  logic [LW-1:0] mdl_len  [NCH];
  int            mon_k    [NCH];
  int            n_beats  [NCH];
  int            exp_stray;
  bit            mon_en, in_pkt, stall_pend;
  int            cur_owner;
  logic [DW-1:0] st_data;
  logic [IDW-1:0] st_tid;
  logic          st_last;

  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) stall_pend = 0;
      else begin
        if (stall_pend) begin
          check("stall_valid", 64'(gen_if.tvalid), 64'd1);
          check("stall_data", gen_if.tdata, st_data);
          check("stall_tid", 64'(gen_if.tid), 64'(st_tid));
          check("stall_last", 64'(gen_if.tlast), 64'(st_last));
        end
        stall_pend = gen_if.tvalid && !gen_if.tready;
        st_data = gen_if.tdata; st_tid = gen_if.tid; st_last = gen_if.tlast;
        if (gen_if.tvalid && gen_if.tready) begin
          int t;
          t = int'(gen_if.tid);
          check("beat_tid_range", 64'(t < int'(NCH)), 64'd1);
          if (t < int'(NCH)) begin
            if (in_pkt) check("pkt_owner_held", 64'(t), 64'(cur_owner));
            check("beat_data", gen_if.tdata, mdl_seed[t] + 64'(mon_k[t]));
            check("beat_last", 64'(gen_if.tlast), 64'(mon_k[t] == int'(mdl_len[t])));
            n_beats[t]++;
            if (gen_if.tlast) begin mon_k[t] = 0; in_pkt = 0; end
            else begin mon_k[t]++; in_pkt = 1; cur_owner = t; end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      rnd_rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic start_ch(input int c, input logic [LW-1:0] l, input logic [DW-1:0] s, input bit accept);
    len_flat[c*LW +: LW] = l;
    seed_flat[c*DW +: DW] = s;
    start[c] = 1'b1;
    if (accept) begin mdl_seed[c] = s; mdl_len[c] = l; mon_k[c] = 0; n_beats[c] = 0; end
    tick();
    start[c] = 1'b0;
  endtask

  task automatic start2(input logic [LW-1:0] l0, input logic [DW-1:0] s0,
                        input logic [LW-1:0] l1, input logic [DW-1:0] s1);
    len_flat = {l1, l0};
    seed_flat = {s1, s0};
    start = 2'b11;
    for (int c = 0; c < int'(NCH); c++) begin mon_k[c] = 0; n_beats[c] = 0; end
    mdl_seed[0] = s0; mdl_len[0] = l0; mdl_seed[1] = s1; mdl_len[1] = l1;
    tick();
    start = '0;
  endtask

  task automatic wait_done(input int c, input int budget);
    int n;
    n = 0;
    while (!done[c] && n < budget) begin tick(); n++; end
    check($sformatf("done_ch%0d_in_time", c), 64'(done[c]), 64'd1);
  endtask

  typedef struct {
    int ch; logic [LW-1:0] len; logic [DW-1:0] seed;
    int corrupt; bit drop; int force_l;
    int exp_err; int exp_stray; int exp_beats;
  } vec_t;
  vec_t tbl [6];

  typedef struct { bit v; int tid; logic [DW-1:0] data; bit last; } obs_t;
  obs_t seq_b [6];

  initial begin
    tbl[0] = '{0, 24'd3, 64'h10,                  -1, 0, -1, 0, 0, 4};
    tbl[1] = '{1, 24'd3, 64'h200,                  2, 1, -1, 2, 0, 4};
    tbl[2] = '{0, 24'd0, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0, -1, 0, 0, 1};
    tbl[3] = '{1, 24'd2, 64'hFFFF_FFFF_FFFF_FFFE, -1, 0, -1, 0, 0, 3};
    tbl[4] = '{0, 24'd4, 64'h5,                    0, 0, -1, 1, 0, 5};
    tbl[5] = '{1, 24'd1, 64'h7,                   -1, 0,  0, 1, 1, 2};
    seq_b[0] = '{1, 0, 64'h0,   0};
    seq_b[1] = '{1, 0, 64'h1,   1};
    seq_b[2] = '{0, 0, 64'h0,   0};
    seq_b[3] = '{1, 1, 64'h100, 0};
    seq_b[4] = '{1, 1, 64'h101, 1};
    seq_b[5] = '{0, 0, 64'h0,   0};

    n_vec = 0; n_err = 0; exp_stray = 0;
    clk = 0; rst = 0; start = '0; len_flat = '0; seed_flat = '0;
    lb = 1; rdy_fix = 1; rdy_rand = 0; drop_last = 0; corrupt_at = -1; force_at = -1;
    man_valid = 0; man_last = 0; man_data = '0; man_tid = '0;
    mon_en = 0; in_pkt = 0; stall_pend = 0; cur_owner = 0;
    for (int c = 0; c < int'(NCH); c++) begin mdl_seed[c] = '0; mdl_len[c] = '0; mon_k[c] = 0; n_beats[c] = 0; end

    // Reset state
    #1 rst = 1;
    #11;
    check("rst_tvalid", 64'(gen_if.tvalid), 64'd0);
    check("rst_tready", 64'(chk_if.tready), 64'd0);
    check("rst_tstrb",  64'(gen_if.tstrb), 64'd0);
    check("rst_busy_done", 64'({busy, done}), 64'd0);
    check("rst_cnts", 64'({err_cnt, stray_cnt}), 64'd0);
    @(posedge clk); #1 rst = 0;
    tick();
    check("tready_after_rst", 64'(chk_if.tready), 64'd1);
    check("tkeep_ones", 64'(gen_if.tkeep), 64'hFF);
    mon_en = 1;

    // Single-channel loopback vectors with optional corruption
    for (int i = 0; i < 6; i++) begin
      corrupt_at = tbl[i].corrupt; drop_last = tbl[i].drop; force_at = tbl[i].force_l;
      start_ch(tbl[i].ch, tbl[i].len, tbl[i].seed, 1);
      wait_done(tbl[i].ch, 100);
      repeat (4) tick();
      exp_stray += tbl[i].exp_stray;
      check($sformatf("vec%0d_err", i), 64'(err_cnt[tbl[i].ch*EW +: EW]), 64'(tbl[i].exp_err));
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
      check($sformatf("vec%0d_beats", i), 64'(n_beats[tbl[i].ch]), 64'(tbl[i].exp_beats));
      check($sformatf("vec%0d_stray", i), 64'(stray_cnt), 64'(exp_stray));
    end
    corrupt_at = -1; drop_last = 0; force_at = -1;

    // Simultaneous start: ch0 packet, one bubble, ch1 packet
    start2(24'd1, 64'h0, 24'd1, 64'h100);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("pair_valid%0d", i), 64'(gen_if.tvalid), 64'(seq_b[i].v));
      if (seq_b[i].v) begin
        check($sformatf("pair_tid%0d", i), 64'(gen_if.tid), 64'(seq_b[i].tid));
        check($sformatf("pair_data%0d", i), gen_if.tdata, seq_b[i].data);
        check($sformatf("pair_last%0d", i), 64'(gen_if.tlast), 64'(seq_b[i].last));
      end
    end
    check("pair_done", 64'(done), 64'h3);
    check("pair_err", 64'(err_cnt), 64'd0);
    start_ch(0, 24'd0, 64'h5, 1);
    wait_done(0, 50);
    repeat (2) tick();
    start2(24'd0, 64'hA0, 24'd0, 64'hB0);
    tick();
    check("rr_rotate_tid", 64'(gen_if.tid), 64'd1);
    check("rr_rotate_data", gen_if.tdata, 64'hB0);
    wait_done(0, 50); wait_done(1, 50);
    repeat (2) tick();

    // Random backpressure, staggered starts
    rdy_rand = 1;
    for (int it = 0; it < 6; it++) begin
      logic [LW-1:0] l0, l1;
      logic [DW-1:0] s0, s1;
      l0 = LW'($urandom_range(0, 15)); l1 = LW'($urandom_range(0, 15));
      s0 = {$urandom, $urandom}; s1 = {$urandom, $urandom};
      start_ch(0, l0, s0, 1);
      repeat ($urandom_range(0, 3)) tick();
      start_ch(1, l1, s1, 1);
      wait_done(0, 400); wait_done(1, 400);
      repeat (3) tick();
      check("rand_err", 64'(err_cnt), 64'd0);
      check("rand_beats0", 64'(n_beats[0]), 64'(l0) + 64'd1);
      check("rand_beats1", 64'(n_beats[1]), 64'(l1) + 64'd1);
    end
    rdy_rand = 0;

    // Stray beats: out-of-range TID and unarmed channel
    lb = 0;
    man_valid = 1; man_tid = 3'd7; tick();
    man_tid = 3'd0; tick();
    man_valid = 0; tick();
    exp_stray += 2;
    check("stray_cnt", 64'(stray_cnt), 64'(exp_stray));
    check("stray_err_untouched", 64'(err_cnt), 64'd0);

    // Start while busy is ignored
    rdy_fix = 0;
    start_ch(0, 24'd5, 64'h40, 1);
    start_ch(0, 24'd0, 64'h99, 0);
    check("busy_while_stalled", 64'(busy[0]), 64'd1);
    tick();
    check("stalled_data_kept", gen_if.tdata, 64'h40);
    lb = 1; rdy_fix = 1;
    wait_done(0, 100);
    repeat (3) tick();
    check("busy_start_err", 64'(err_cnt[EW-1:0]), 64'd0);
    check("busy_start_beats", 64'(n_beats[0]), 64'd6);

    // Reset mid-packet, then a clean restart
    start_ch(0, 24'd3, 64'h30, 1);
    begin
      int n;
      n = 0;
      while (!(gen_if.tvalid && gen_if.tdata == 64'h31) && n < 20) begin tick(); n++; end
      check("reach_beat1", 64'(n < 20), 64'd1);
    end
    mon_en = 0;
    rst = 1;
    #1;
    check("midrst_bus", 64'({gen_if.tvalid, gen_if.tlast, gen_if.tid}), 64'd0);
    check("midrst_data", gen_if.tdata, 64'd0);
    check("midrst_status", 64'({busy, done, chk_if.tready}), 64'd0);
    check("midrst_cnts", 64'({err_cnt, stray_cnt}), 64'd0);
    tick(); tick();
    rst = 0;
    exp_stray = 0; in_pkt = 0;
    for (int c = 0; c < int'(NCH); c++) mon_k[c] = 0;
    tick();
    mon_en = 1;
    start_ch(0, 24'd3, 64'h30, 1);
    wait_done(0, 100);
    repeat (3) tick();
    check("restart_err", 64'(err_cnt[EW-1:0]), 64'd0);
    check("restart_beats", 64'(n_beats[0]), 64'd4);
    check("restart_stray", 64'(stray_cnt), 64'(exp_stray));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
